// File: rtl/multicycle_alu.sv
// Handshaked execute unit: single-cycle ALU ops plus an iterative shift-add multiply.
// Results sit in an output register that holds until the consumer takes them.
module multicycle_alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_AND = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_ORR = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_NOT = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_TCP = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_SHL = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_SHR = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_ORI = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_LHI = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_GTZ = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_ID  = OPW'(4'hB);
  localparam logic [OPW-1:0] OP_EQ  = OPW'(4'hC);
  localparam logic [OPW-1:0] OP_NEQ = OPW'(4'hD);
  localparam logic [OPW-1:0] OP_LTZ = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_MUL = OPW'(4'hF);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_c_reg;
  logic                 out_ovf_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mult_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        cnt_reg;

  logic                 accept;
  logic                 accept_mul;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     alu_c;
  logic                 alu_ovf;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     diff;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept_mul) state_next = S_MUL;
      S_MUL:   if (mul_last)   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready   = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
    busy       = (state_reg == S_MUL);
    accept     = in_valid && in_ready;
    accept_mul = accept && (in_op == OP_MUL);
    mul_last   = (state_reg == S_MUL) && (cnt_reg == CNT_LAST);
  end

  assign sum      = in_a + in_b;
  assign diff     = in_a - in_b;
  assign acc_next = acc_reg + (mult_reg[0] ? mcand_reg : '0);

  // Single-cycle ops; MUL never takes this path so its entry stays zero
  always_comb begin
    alu_c   = '0;
    alu_ovf = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_c   = sum;
        alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c   = diff;
        alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND: alu_c = in_a & in_b;
      OP_ORR: alu_c = in_a | in_b;
      OP_NOT: alu_c = ~in_a;
      OP_TCP: alu_c = ~in_a + WIDTH'(1);
      OP_SHL: alu_c = {in_a[WIDTH-2:0], 1'b0};
      OP_SHR: alu_c = {in_a[WIDTH-1], in_a[WIDTH-1:1]};
      OP_ORI: alu_c = in_a | {{(WIDTH-8){1'b0}}, in_b[7:0]};
      OP_LHI: alu_c = {in_b[7:0], {(WIDTH-8){1'b0}}};
      OP_GTZ: alu_c = WIDTH'(!in_a[WIDTH-1] && (|in_a));
      OP_ID:  alu_c = in_a;
      OP_EQ:  alu_c = WIDTH'(in_a == in_b);
      OP_NEQ: alu_c = WIDTH'(in_a != in_b);
      OP_LTZ: alu_c = WIDTH'(in_a[WIDTH-1]);
      OP_MUL: alu_c = '0;
      default: alu_c = '0;
    endcase
  end

  // Shift-add multiplier: multiplicand shifts left, multiplier shifts right
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg <= '0;
      mult_reg  <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (accept_mul) begin
      mcand_reg <= {{WIDTH{1'b0}}, in_a};
      mult_reg  <= in_b;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == S_MUL) begin
      mcand_reg <= {mcand_reg[2*WIDTH-2:0], 1'b0};
      mult_reg  <= {1'b0, mult_reg[WIDTH-1:1]};
      acc_reg   <= acc_next;
      cnt_reg   <= mul_last ? '0 : cnt_reg + CW'(1);
    end
  end

  // Output register: a new completion wins over a drain; otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_c_reg     <= '0;
      out_ovf_reg   <= 1'b0;
    end else if (accept && !accept_mul) begin
      out_valid_reg <= 1'b1;
      out_c_reg     <= alu_c;
      out_ovf_reg   <= alu_ovf;
    end else if (mul_last) begin
      out_valid_reg <= 1'b1;
      out_c_reg     <= acc_next[WIDTH-1:0];
      out_ovf_reg   <= |acc_next[2*WIDTH-1:WIDTH];
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_c     = out_c_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=16): vector table plus
// hand sequences for output hold, back-to-back accept and mid-multiply reset.
module tb_multicycle_alu;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_c;
  logic          out_ovf;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_alu #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one op with out_ready=1; report result, latency and whether
  // in_ready stayed low / busy stayed high while waiting.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] c, output logic ovf, output int lat,
                        output logic hold_ok);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    hold_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    c = out_c;
    ovf = out_ovf;
  endtask

  initial begin
    logic [W-1:0] c;
    logic         ovf;
    int           lat;
    logic         hold_ok;
    logic         stale;

    vecs[0]  = '{"add_ovf",  4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1};
    vecs[1]  = '{"sub_ovf",  4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1};
    vecs[2]  = '{"add",      4'h0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1};
    vecs[3]  = '{"sub_neg",  4'h1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1};
    vecs[4]  = '{"add_nn",   4'h0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1};
    vecs[5]  = '{"and",      4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1};
    vecs[6]  = '{"orr",      4'h3, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1};
    vecs[7]  = '{"not",      4'h4, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 1};
    vecs[8]  = '{"tcp",      4'h5, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1};
    vecs[9]  = '{"shl",      4'h6, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1};
    vecs[10] = '{"shr",      4'h7, 16'h8002, 16'h0000, 16'hC001, 1'b0, 1};
    vecs[11] = '{"ori",      4'h8, 16'h1200, 16'hFF34, 16'h1234, 1'b0, 1};
    vecs[12] = '{"lhi",      4'h9, 16'h5555, 16'h00AB, 16'hAB00, 1'b0, 1};
    vecs[13] = '{"gtz_neg",  4'hA, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[14] = '{"gtz_pos",  4'hA, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1};
    vecs[15] = '{"gtz_zero", 4'hA, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[16] = '{"id",       4'hB, 16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1};
    vecs[17] = '{"eq",       4'hC, 16'h0005, 16'h0005, 16'h0001, 1'b0, 1};
    vecs[18] = '{"neq_eq",   4'hD, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1};
    vecs[19] = '{"neq_ne",   4'hD, 16'h0005, 16'h0006, 16'h0001, 1'b0, 1};
    vecs[20] = '{"ltz_neg",  4'hE, 16'h8000, 16'h0000, 16'h0001, 1'b0, 1};
    vecs[21] = '{"ltz_pos",  4'hE, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[22] = '{"mul",      4'hF, 16'h0123, 16'h0010, 16'h1230, 1'b0, 17};
    vecs[23] = '{"mul_ovf",  4'hF, 16'h0100, 16'h0100, 16'h0000, 1'b1, 17};
    vecs[24] = '{"mul_one",  4'hF, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17};
    vecs[25] = '{"mul_zero", 4'hF, 16'h0000, 16'h1234, 16'h0000, 1'b0, 17};

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_c",     32'(out_c),     32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, c, ovf, lat, hold_ok);
      chk({vecs[i].name, "_c"},   32'(c),   32'(vecs[i].c));
      chk({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].ovf));
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].op == 4'hF) chk({vecs[i].name, "_stall"}, 32'(hold_ok), 32'd1);
      $display("[TB] %-8s a=%h b=%h -> c=%h ovf=%0d lat=%0d", vecs[i].name, vecs[i].a, vecs[i].b, c, ovf, lat);
    end
    @(posedge clk); #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Output hold under backpressure, then accept on the release cycle
    out_ready = 1'b0;
    in_op = 4'h0; in_a = 16'h0001; in_b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_c",     32'(out_c),     32'h0002);
      chk("hold_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    in_op = 4'h0; in_a = 16'h0003; in_b = 16'h0004; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_c",     32'(out_c),     32'h0007);
    $display("[TB] hold/back-to-back: c=%h", out_c);
    @(posedge clk); #1;
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset on the 6th multiply cycle must abort with no stale result
    in_op = 4'hF; in_a = 16'h00FF; in_b = 16'h00FF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_mul_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_valid",    32'(out_valid), 32'd0);
    chk("abort_busy",     32'(busy),      32'd0);
    chk("abort_in_ready", 32'(in_ready),  32'd1);
    stale = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid || busy) stale = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_stale", 32'(stale), 32'd0);
    $display("[TB] mid-MUL reset: valid=%0d busy=%0d", out_valid, busy);

    run_op(4'hB, 16'h1234, 16'h0000, c, ovf, lat, hold_ok);
    chk("post_rst_id_c",   32'(c),   32'h1234);
    chk("post_rst_id_lat", 32'(lat), 32'd1);
    $display("[TB] id after reset -> c=%h lat=%0d", c, lat);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
